alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue queue: decodes requests into ALU commands, one cycle from accept to out_valid.
// Backpressure: in_ready drops only when the queue is full; illegal funcs are acked and dropped.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Ready comes from the registered count only, so no path from rd_rdy.
    assign wr_rdy = (count < CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wrap_inc(wptr);
            if (pop)  rptr <= wrap_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_dat;
    end
endmodule

module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [2:0]  in_func,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_cin,
    output logic        out_less,
    output logic [2:0]  out_op,
    output logic        err_pulse,
    output logic [7:0]  illegal_cnt,
    output logic [15:0] issue_cnt
);
    typedef struct packed {
        logic [2:0]  op;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    cmd_t dec;
    cmd_t head;
    logic legal;
    logic push_vld;
    logic accept;

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        dec.a = in_a;
        case (in_func)
            3'b000: begin dec.op = 3'b000; dec.b = in_b; end
            3'b001: begin dec.op = 3'b001; dec.b = in_b; end
            3'b010: begin dec.op = 3'b010; dec.b = in_b; end
            // SUB and SLT both run through the adder as a + ~b + 1.
            3'b011: begin dec.op = 3'b010; dec.b = ~in_b; dec.cin = 1'b1; end
            3'b100: begin dec.op = 3'b111; dec.b = ~in_b; dec.cin = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    assign push_vld = in_valid && legal;
    assign accept   = in_valid && in_ready;

    fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_vld),
        .wr_rdy (in_ready),
        .wr_dat (dec),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head)
    );

    assign out_a    = out_valid ? head.a   : '0;
    assign out_b    = out_valid ? head.b   : '0;
    assign out_cin  = out_valid ? head.cin : 1'b0;
    assign out_op   = out_valid ? head.op  : '0;
    assign out_less = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse   <= 1'b0;
            illegal_cnt <= '0;
            issue_cnt   <= '0;
        end else begin
            err_pulse <= accept && !legal;
            if (accept && !legal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 1'b1;
            if (out_valid && out_ready)
                issue_cnt <= issue_cnt + 1'b1;
        end
    end
endmodule
